mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage access controller for the RISC-V pipeline. Sits between the EX/MEM register and the load truncate/extend stage. Issues word-aligned requests to the data-memory bus using a req/ack handshake, and generates byte enables and lane-shifted write data for stores. For loads, it captures the raw bus word and forwards it downstream with the byte offset (ReadControl) and extension code (DexControl). While an access is outstanding, it stalls the pipeline.

Parameters:
TIMEOUT_CYCLES, 256, cycles in WAIT without BusAck before the access aborts with BusErr.
CNT_W, 9, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
MemRead  in  1  load request from EX/MEM.
MemWrite  in  1  store request from EX/MEM.
Addr  in  32  byte address.
WriteData  in  32  store data, right-aligned.
Funct3  in  3  size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
BusReq  out  1  bus request.
BusWe  out  1  bus write enable.
BusAddr  out  32  word address, {Addr[31:2],2'b00}.
BusWData  out  32  lane-aligned store data.
BusByteEn  out  4  store byte lanes.
BusAck  in  1  bus completion, single-cycle pulse.
BusRData  in  32  read word, valid when BusAck=1.
LoadWord  out  32  captured raw word, feeds truncate Src.
ReadControl  out  2  captured Addr[1:0].
DexControl  out  3  captured Funct3.
LoadValid  out  1  one-cycle pulse: LoadWord/ReadControl/DexControl valid.
Stall  out  1  freeze upstream pipeline.
MisalignErr  out  1  one-cycle pulse: misaligned access rejected.
BusErr  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all outputs 0, including LoadWord, ReadControl, DexControl.
  - Timeout counter cleared.
  - BusReq drops immediately, even mid-transaction.
- Start condition: start = MemRead|MemWrite in IDLE. If both are asserted, the access is a read and BusWe=0.
- Misalignment:
  - Halfword (Funct3[1:0]=01) is misaligned when Addr[1:0]=11.
  - Word (Funct3[1:0]=10) is misaligned when Addr[1:0]!=00.
  - Byte access is never misaligned.
- Misaligned start: no bus access. MisalignErr=1 on the next cycle; Stall=0; state stays IDLE.
- Funct3 codes 011/110/111 are treated as word (byte enables 1111, alignment check as word). They are forwarded unchanged on DexControl.
- FSM states:
  - IDLE: on aligned start, register address/data/enables/Funct3, go to WAIT. Stall=1 combinationally during the start cycle.
  - WAIT: BusReq=1. BusWe, BusAddr, BusWData, BusByteEn are held stable and unchanged until exit. Stall=1. The counter increments each cycle.
    - BusAck=1: capture BusRData into LoadWord (reads only; writes leave LoadWord unchanged), go to RESP, clear the counter.
    - Counter reaches TIMEOUT_CYCLES-1 without ack: go to IDLE, BusErr=1 for one cycle, LoadWord unchanged.
    - If BusAck arrives on the expiry cycle, BusAck wins.
  - RESP: BusReq=0, Stall=0. LoadValid=1 for reads only. Next state IDLE. New requests are not accepted in RESP; the pipeline advances at the end of RESP.
- Latency: start at cycle 0, BusReq from cycle 1, ack at cycle k≥1, LoadValid in cycle k+1. Stall is high cycles 0..k.
- BusAck in IDLE/RESP is ignored.
- Store lanes (off=Addr[1:0]):
  - Byte: BusByteEn=0001<<off; BusWData={4{WriteData[7:0]}}.
  - Half: BusByteEn=0011<<off; BusWData=WriteData[15:0]<<(8*off).
  - Word: BusByteEn=1111; BusWData=WriteData.
- For reads, BusByteEn=0000 and BusWData=0.
- ReadControl/DexControl update only on the LoadValid cycle and hold otherwise.

Decomposition:
- Shared package mem_pkg:
  - Funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encoding ST_IDLE/ST_WAIT/ST_RESP.
  - BusByteEn patterns.
- One combinational sub-module, store_align: inputs Funct3, Addr[1:0], WriteData; outputs BusByteEn, BusWData, misaligned flag.
- The FSM, counter and capture registers stay in mem_access_unit.

Test Plan:
- lb at 0x1003, BusAck 3 cycles after BusReq, BusRData=0x80AA55CC:
  - Stall high 4 cycles.
  - LoadValid pulse with LoadWord=0x80AA55CC, ReadControl=11, DexControl=000, BusAddr=0x1000.
- sh at 0x2001, WriteData=0x0000BEEF, immediate ack:
  - BusWe=1, BusByteEn=0110, BusWData=0x00BEEF00.
  - No LoadValid.
- lw at 0x3002: MisalignErr pulse, BusReq never asserts, Stall=0. Also sh at offset 11 → MisalignErr.
- Read with no BusAck: after TIMEOUT_CYCLES cycles in WAIT, BusErr pulse, BusReq=0, state IDLE, LoadWord unchanged.
- rst_n low mid-WAIT: BusReq=0 asynchronously, all outputs 0; an aligned lw afterwards completes normally.
- MemRead=MemWrite=1 at 0x4000: BusWe=0, read completes with LoadValid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory-stage access path: Funct3 size codes,
// FSM state encoding and store byte-enable base patterns.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Store lane steering: byte enables, lane-shifted write data and the
// misalignment flag for a given size code and byte offset.
module store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic        misaligned
);

  always_comb begin
    byte_en    = BE_WORD;
    lane_data  = wdata;
    misaligned = 1'b0;
    // Only the low two bits select size; reserved codes fall through as word.
    unique case (funct3[1:0])
      2'b00: begin
        byte_en   = BE_BYTE << off;
        lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = BE_HALF << off;
        lane_data  = {16'h0000, wdata[15:0]} << {off, 3'b000};
        misaligned = (off == 2'b11);
      end
      default: begin
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues word-aligned req/ack bus accesses,
// stalls the pipeline while outstanding and captures load data for extension.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusByteEn,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic [31:0] LoadWord,
  output logic [1:0]  ReadControl,
  output logic [2:0]  DexControl,
  output logic        LoadValid,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             start;
  logic             misaligned;
  logic [3:0]       st_be;
  logic [31:0]      st_data;

  store_align u_align (
    .funct3     (Funct3),
    .off        (Addr[1:0]),
    .wdata      (WriteData),
    .byte_en    (st_be),
    .lane_data  (st_data),
    .misaligned (misaligned)
  );

  assign start     = (MemRead | MemWrite) && (state == ST_IDLE);
  assign BusReq    = (state == ST_WAIT);
  assign LoadValid = (state == ST_RESP) && !BusWe;
  assign Stall     = (state == ST_WAIT) || (start && !misaligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      BusWe       <= 1'b0;
      BusAddr     <= '0;
      BusWData    <= '0;
      BusByteEn   <= '0;
      LoadWord    <= '0;
      ReadControl <= '0;
      DexControl  <= '0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
    end else begin
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (misaligned) begin
              MisalignErr <= 1'b1;
            end else begin
              // A simultaneous read+write request is serviced as a read.
              BusWe     <= MemWrite & ~MemRead;
              BusAddr   <= {Addr[31:2], 2'b00};
              BusWData  <= MemRead ? '0 : st_data;
              BusByteEn <= MemRead ? '0 : st_be;
              f3_q      <= Funct3;
              off_q     <= Addr[1:0];
              cnt       <= '0;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (BusAck) begin
            if (!BusWe) begin
              LoadWord    <= BusRData;
              ReadControl <= off_q;
              DexControl  <= f3_q;
            end
            cnt   <= '0;
            state <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            BusErr <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver pushes expected
// bus requests and result events, the monitor pops and compares them.
module tb_mem_access_unit;

  localparam int TO = 256;
  localparam int K_LOAD = 1;
  localparam int K_BERR = 2;
  localparam int K_MIS  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [2:0]  Funct3 = '0;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusByteEn;
  logic        BusAck = 1'b0;
  logic [31:0] BusRData = '0;
  logic [31:0] LoadWord;
  logic [1:0]  ReadControl;
  logic [2:0]  DexControl;
  logic        LoadValid, Stall, MisalignErr, BusErr;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .Funct3(Funct3),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .BusAck(BusAck), .BusRData(BusRData),
    .LoadWord(LoadWord), .ReadControl(ReadControl), .DexControl(DexControl),
    .LoadValid(LoadValid), .Stall(Stall), .MisalignErr(MisalignErr), .BusErr(BusErr)
  );

  typedef struct {
    int          kind;
    logic [31:0] word;
    logic [1:0]  rc;
    logic [2:0]  dex;
  } ev_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  ev_t         exp_q[$];
  bus_t        bus_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_word = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic take(input int k);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL spurious_event: got kind %0d expected none at %0t", k, $time);
      return;
    end
    total--;
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    if (k == K_LOAD) begin
      check("load_word", LoadWord, e.word);
      check("read_control", {30'd0, ReadControl}, {30'd0, e.rc});
      check("dex_control", {29'd0, DexControl}, {29'd0, e.dex});
    end else if (k == K_BERR) begin
      check("berr_loadword_kept", LoadWord, e.word);
      check("berr_busreq", {31'd0, BusReq}, 32'd0);
    end else begin
      check("mis_busreq", {31'd0, BusReq}, 32'd0);
    end
  endtask

  // Monitor
  initial begin
    bus_t cur;
    logic prev;
    prev = 1'b0;
    cur = '{we: 1'b0, addr: '0, wdata: '0, be: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      if (BusReq && !prev) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_busreq: got BusReq=1 addr %h expected no request", BusAddr);
        end else begin
          cur = bus_q.pop_front();
          check("bus_we", {31'd0, BusWe}, {31'd0, cur.we});
          check("bus_addr", BusAddr, cur.addr);
          check("bus_wdata", BusWData, cur.wdata);
          check("bus_be", {28'd0, BusByteEn}, {28'd0, cur.be});
        end
      end else if (BusReq) begin
        check("bus_stable", {BusWe, BusByteEn, BusAddr[26:0]}, {cur.we, cur.be, cur.addr[26:0]});
        check("bus_wdata_stable", BusWData, cur.wdata);
      end
      prev = BusReq;
      if (LoadValid)   take(K_LOAD);
      if (BusErr)      take(K_BERR);
      if (MisalignErr) take(K_MIS);
    end
  end

  // d: number of WAIT cycles up to and including the ack cycle; 0 = never ack.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] wd, input logic [2:0] f3, input int d,
                    input logic [31:0] rdata);
    int   size, off, limit;
    ev_t  e;
    bus_t b;
    off  = int'(a[1:0]);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd; Funct3 = f3;
    if (off + size > 4) begin
      e = '{kind: K_MIS, word: '0, rc: '0, dex: '0};
      exp_q.push_back(e);
      #1 check("stall_misaligned", {31'd0, Stall}, 32'd0);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      return;
    end
    b.we   = !rd;
    b.addr = a & 32'hFFFF_FFFC;
    b.be   = rd ? 4'b0000 : 4'(((1 << size) - 1) << off);
    if (rd)             b.wdata = '0;
    else if (size == 1) b.wdata = {4{wd[7:0]}};
    else if (size == 2) b.wdata = (wd & 32'h0000_FFFF) << (8 * off);
    else                b.wdata = wd;
    bus_q.push_back(b);
    if (d == 0) begin
      e = '{kind: K_BERR, word: last_word, rc: '0, dex: '0};
      exp_q.push_back(e);
    end else if (rd) begin
      e = '{kind: K_LOAD, word: rdata, rc: a[1:0], dex: f3};
      exp_q.push_back(e);
      last_word = rdata;
    end
    #1 check("stall_start", {31'd0, Stall}, 32'd1);
    check("busreq_start", {31'd0, BusReq}, 32'd0);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    limit = (d == 0) ? TO : d;
    for (int n = 1; n <= limit; n++) begin
      check("stall_wait", {31'd0, Stall}, 32'd1);
      if (n == d) begin
        BusAck = 1'b1; BusRData = rdata;
      end
      @(negedge clk);
      BusAck = 1'b0; BusRData = $urandom;
    end
    check("stall_after", {31'd0, Stall}, 32'd0);
    check("busreq_after", {31'd0, BusReq}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #1;
    check("rst_busreq", {31'd0, BusReq}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_loadword", LoadWord, 32'd0);
    check("rst_ctrl", {27'd0, ReadControl, DexControl}, 32'd0);
    check("rst_pulses", {29'd0, LoadValid, MisalignErr, BusErr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(1'b1, 1'b0, 32'h0000_1003, 32'h0, 3'b000, 3, 32'h80AA_55CC);
    op(1'b0, 1'b1, 32'h0000_2001, 32'h0000_BEEF, 3'b001, 1, 32'h1234_5678);
    op(1'b1, 1'b0, 32'h0000_3002, 32'h0, 3'b010, 1, 32'h0);
    op(1'b0, 1'b1, 32'h0000_2003, 32'h0000_BEEF, 3'b001, 1, 32'h0);

    // Stray ack while idle must produce nothing.
    @(negedge clk); BusAck = 1'b1; BusRData = 32'hDEAD_BEEF;
    @(negedge clk); BusAck = 1'b0;

    op(1'b1, 1'b0, 32'h0000_6000, 32'h0, 3'b010, 0, 32'h0);

    // Reset in the middle of a pending read.
    begin
      bus_t b;
      @(negedge clk);
      MemRead = 1'b1; Addr = 32'h0000_5000; Funct3 = 3'b010;
      b = '{we: 1'b0, addr: 32'h0000_5000, wdata: '0, be: '0};
      bus_q.push_back(b);
      @(negedge clk); MemRead = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("midrst_busreq", {31'd0, BusReq}, 32'd0);
      check("midrst_stall", {31'd0, Stall}, 32'd0);
      check("midrst_loadword", LoadWord, 32'd0);
      check("midrst_bus", {BusWe, BusByteEn, BusAddr[26:0]}, 32'd0);
      exp_q.delete();
      last_word = '0;
      @(negedge clk); rst_n = 1'b1;
    end

    op(1'b1, 1'b0, 32'h0000_7000, 32'h0, 3'b010, 2, 32'hCAFE_F00D);
    op(1'b1, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 3'b010, 1, 32'h0BAD_C0DE);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      op(r[0], r[1], $urandom, $urandom, 3'($urandom_range(0, 7)),
         $urandom_range(1, 5), $urandom);
    end

    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 32'd0);
    check("bus_queue_empty", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
